// File: rtl/xy_route_stage.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | Module      : xy_route_stage                                          |
// | Description : XY route computation with per-packet port lock and a   |
// |               2-entry {sel, flit} FIFO feeding the output demux.      |
// | Revision    : 1.0 - initial release                                   |
// +-----------------------------------------------------------------------+
module xy_route_stage #(
    parameter int DATA_W  = 32,
    parameter int COORD_W = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [COORD_W-1:0] cur_x,
    input  logic [COORD_W-1:0] cur_y,
    input  logic [DATA_W-1:0]  in_flit,
    input  logic               in_valid,
    output logic               in_ready,
    output logic [DATA_W-1:0]  out_flit,
    output logic [2:0]         out_sel,
    output logic               out_valid,
    input  logic               out_ready,
    output logic               err
);

    localparam logic [0:0] c_st_idle   = 1'b0;
    localparam logic [0:0] c_st_in_pkt = 1'b1;

    localparam logic [1:0] c_type_body   = 2'b00;
    localparam logic [1:0] c_type_head   = 2'b01;
    localparam logic [1:0] c_type_tail   = 2'b10;
    localparam logic [1:0] c_type_single = 2'b11;

    localparam logic [2:0] c_port_local = 3'b000;
    localparam logic [2:0] c_port_north = 3'b001;
    localparam logic [2:0] c_port_east  = 3'b010;
    localparam logic [2:0] c_port_south = 3'b011;
    localparam logic [2:0] c_port_west  = 3'b100;

    logic [0:0]         r_state;
    logic [2:0]         r_route;
    logic [1:0]         r_cnt;
    logic               r_wptr;
    logic               r_rptr;
    logic               r_err;
    logic [DATA_W-1:0]  r_mem_flit [2];
    logic [2:0]         r_mem_sel  [2];

    logic [1:0]         w_type;
    logic [COORD_W-1:0] w_dst_x;
    logic [COORD_W-1:0] w_dst_y;
    logic [2:0]         w_route;
    logic               w_accept;
    logic               w_push;
    logic               w_pop;
    logic [2:0]         w_push_sel;
    logic               w_err;
    logic [0:0]         w_nxt_state;
    logic [2:0]         w_nxt_route;

    assign w_type   = in_flit[DATA_W-1:DATA_W-2];
    assign w_dst_x  = in_flit[2*COORD_W-1:COORD_W];
    assign w_dst_y  = in_flit[COORD_W-1:0];

    assign in_ready  = (r_cnt != 2'd2);
    assign out_valid = (r_cnt != 2'd0);
    assign out_flit  = r_mem_flit[r_rptr];
    assign out_sel   = r_mem_sel[r_rptr];
    assign err       = r_err;

    assign w_accept = in_valid & in_ready;
    assign w_pop    = out_valid & out_ready;

    // Dimension-ordered routing: resolve X first, then Y.
    always_comb begin
        w_route = c_port_local;
        if (w_dst_x > cur_x)
            w_route = c_port_east;
        else if (w_dst_x < cur_x)
            w_route = c_port_west;
        else if (w_dst_y > cur_y)
            w_route = c_port_north;
        else if (w_dst_y < cur_y)
            w_route = c_port_south;
    end

    always_comb begin
        w_push      = 1'b0;
        w_push_sel  = w_route;
        w_err       = 1'b0;
        w_nxt_state = r_state;
        w_nxt_route = r_route;
        if (w_accept) begin
            case (r_state)
                c_st_idle: begin
                    case (w_type)
                        c_type_head: begin
                            w_push      = 1'b1;
                            w_nxt_route = w_route;
                            w_nxt_state = c_st_in_pkt;
                        end
                        c_type_single: w_push = 1'b1;
                        default:       w_err  = 1'b1;
                    endcase
                end
                default: begin
                    case (w_type)
                        c_type_body: begin
                            w_push     = 1'b1;
                            w_push_sel = r_route;
                        end
                        c_type_tail: begin
                            w_push      = 1'b1;
                            w_push_sel  = r_route;
                            w_nxt_state = c_st_idle;
                        end
                        c_type_head: begin
                            // Unterminated packet: start the new one anyway.
                            w_push      = 1'b1;
                            w_err       = 1'b1;
                            w_nxt_route = w_route;
                        end
                        default: begin
                            w_push      = 1'b1;
                            w_err       = 1'b1;
                            w_nxt_state = c_st_idle;
                        end
                    endcase
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state       <= c_st_idle;
            r_route       <= c_port_local;
            r_err         <= 1'b0;
            r_cnt         <= 2'd0;
            r_wptr        <= 1'b0;
            r_rptr        <= 1'b0;
            r_mem_flit[0] <= '0;
            r_mem_flit[1] <= '0;
            r_mem_sel[0]  <= c_port_local;
            r_mem_sel[1]  <= c_port_local;
        end else begin
            r_state <= w_nxt_state;
            r_route <= w_nxt_route;
            r_err   <= w_err;
            if (w_push) begin
                r_mem_flit[r_wptr] <= in_flit;
                r_mem_sel[r_wptr]  <= w_push_sel;
                r_wptr             <= ~r_wptr;
            end
            if (w_pop)
                r_rptr <= ~r_rptr;
            case ({w_push, w_pop})
                2'b10:   r_cnt <= r_cnt + 2'd1;
                2'b01:   r_cnt <= r_cnt - 2'd1;
                default: r_cnt <= r_cnt;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: doc/xy_route_stage.md
# xy_route_stage

Route-computation and buffering stage placed directly upstream of the router's 1-to-5 output demux. Accepts flits on a valid/ready channel, computes the XY-routing output port from the head flit, locks that port for the rest of the packet, and presents each flit with its 3-bit port select from a 2-entry FIFO. The select uses the demux's encoding, so `out_sel` drives the demux select without translation.

## Interface
- `DATA_W`, default 32: flit width in bits; minimum 10.
- `COORD_W`, default 4: width of each X/Y coordinate.
- `clk`  in  1: single clock; all state updates on the rising edge.
- `rst_n`  in  1: asynchronous, active-low reset.
- `cur_x`, `cur_y`  in  COORD_W each: this router's coordinates; quasi-static, unsigned.
- `in_flit`  in  DATA_W: incoming flit.
- `in_valid`  in  1: `in_flit` is valid.
- `in_ready`  out  1: stage can accept a flit this cycle.
- `out_flit`  out  DATA_W: flit at the FIFO head.
- `out_sel`  out  3: port select for `out_flit`.
- `out_valid`  out  1: FIFO head is valid.
- `out_ready`  in  1: downstream consumes the head this cycle.
- `err`  out  1: one-cycle pulse on a framing error.

## Operation
- Flit type field `in_flit[DATA_W-1:DATA_W-2]`:
  - 01 = head
  - 00 = body
  - 10 = tail
  - 11 = single, meaning head and tail together.
- Head destination fields: `dst_x = in_flit[2*COORD_W-1:COORD_W]`, `dst_y = in_flit[COORD_W-1:0]`.
- Port encoding, matching the demux outputs 1..5:
  - 000 = local
  - 001 = north
  - 010 = east
  - 011 = south
  - 100 = west
  - 101–111 are never produced.
- XY routing uses unsigned compares:
  - `dst_x > cur_x` → east; `dst_x < cur_x` → west.
  - Otherwise, `dst_y > cur_y` → north; `dst_y < cur_y` → south.
  - Otherwise → local.
- Accept condition: `in_valid & in_ready`.
- State machine:
  - States are IDLE and IN_PKT. A `route_q` register (3 bits) holds the locked port.
  - IDLE, accepted head: compute route, store in `route_q`, push, go to IN_PKT.
  - IDLE, accepted single: compute route, push, stay in IDLE. `route_q` is unchanged.
  - IDLE, accepted body or tail: flit is dropped (not pushed), `err` pulses, stay in IDLE.
  - IN_PKT, accepted body: push with `route_q`, stay in IN_PKT.
  - IN_PKT, accepted tail: push with `route_q`, go to IDLE.
  - IN_PKT, accepted head: treated as a new packet. Compute route, overwrite `route_q`, push, pulse `err`, stay in IN_PKT.
  - IN_PKT, accepted single: compute route, push, pulse `err`, go to IDLE.
- FIFO: 2 entries of `{sel, flit}`, with a 2-bit count (0..2) and 1-bit read/write pointers that wrap.
  - `in_ready = (count != 2)`, independent of `out_ready` and of the flit type.
  - `out_valid = (count != 0)`; `out_flit` and `out_sel` come from the head entry.
  - Push and pop in the same cycle: count unchanged, both pointers advance.
  - Dropped flits never change the FIFO.
  - Contents are held while `out_valid & ~out_ready`.

## Timing
- Reset values: state IDLE, `route_q`=000, count=0, pointers=0, `out_valid`=0, `out_flit`=0, `out_sel`=000, `err`=0, `in_ready`=1.
- Asynchronous reset mid-packet discards FIFO contents and packet state immediately. The first flit after reset is parsed in IDLE.
- Latency: a flit accepted at edge t is on `out_flit`/`out_sel` with `out_valid`=1 in the cycle after t, when the FIFO was empty.
- Throughput: 1 flit/cycle sustained while `out_ready`=1.
- With `out_ready`=0, exactly 2 flits are accepted, then `in_ready` falls. `in_ready` rises in the cycle after the first pop.
- `err` is registered: it is high for the one cycle following the edge that accepted the offending flit.
- `cur_x`/`cur_y` are sampled only at head/single acceptance.

## Test plan
- `cur`=(2,2); singles to (3,2), (1,2), (2,3), (2,1), (2,2), `out_ready`=1 → `out_sel` 010, 100, 001, 011, 000 on consecutive cycles, each 1 cycle after its input; `err` stays 0.
- `cur`=(0,0); head to (5,5), 2 bodies, tail, then single to (0,0) → first four flits carry 010, single carries 000; state returns to IDLE after the tail.
- `out_ready`=0; 3 consecutive flits offered → first 2 accepted, `in_ready`=0 with the 3rd held. Raise `out_ready` → 3rd flit accepted 1 cycle after the first pop, output order preserved.
- Body flit in IDLE → not output, `err`=1 for exactly one cycle. Head in IN_PKT → re-routed, output, `err` pulses once.
- Assert `rst_n`=0 mid-packet with 2 flits buffered → `out_valid`=0 and `in_ready`=1 immediately. A body flit after release → dropped with `err`.
- Simultaneous push and pop at count=1 for 10 cycles → count stays 1, all flits delivered in order across pointer wrap.
